ntt_stage_ctrl: RTL and testbench
=================================

// Module: ntt_stage_ctrl
// PURPOSE
//  Upstream sequencer for the AGU integration block. Walks one transform through K1_STAGES
//  radix-16 stages and then one final radix-2 stage. Drives AGU_enable / AGU_enable_k2 /
//  LAST_STAGE and consumes AGU_done_out and BN_MA_out_en. Inserts a drain gap between stages.
//  Checks per-stage address-beat counts.
// PARAMETERS
//  K1_STAGES     3     number of radix-16 stages before the final radix-2 stage (>=1)
//  BEATS_K1      256   BN_MA_out_en beats expected per radix-16 stage
//  BEATS_K2      2048  BN_MA_out_en beats expected in the radix-2 stage
//  DRAIN_CYCLES  8     idle cycles after AGU_done_out before the next stage launches (>=1)
//  TIMEOUT       4096  max cycles per stage; used only with STAGE_CTRL_TIMEOUT_EN
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous reset, active-low
//  start_valid   in   1   request a full transform
//  start_ready   out  1   high in IDLE; accepted when start_valid&&start_ready
//  AGU_done_out  in   1   end-of-stage pulse from the AGU integration block
//  BN_MA_out_en  in   1   one address beat issued by the AGU
//  AGU_enable    out  1   radix-16 stage run (level)
//  AGU_enable_k2 out  1   radix-2 stage run (level)
//  LAST_STAGE    out  1   selects the radix-2 address path; high in the final stage and its drain
//  stage_idx     out  $clog2(K1_STAGES+1)  current stage number, 0..K1_STAGES
//  busy          out  1   high in any state other than IDLE
//  done          out  1   one-cycle pulse when the transform completes
//  beat_err      out  1   sticky: a stage ended with beat count != expected
//  timeout_err   out  1   sticky: stage exceeded TIMEOUT (STAGE_CTRL_TIMEOUT_EN only)
// BEHAVIOUR
//  Reset (rst==0 at posedge): FSM=IDLE; all outputs 0 except start_ready=1; counters=0.
//   Reset mid-stage aborts immediately. No done pulse is produced.
//  FSM: IDLE -> RUN on start handshake: stage_idx=0, beat_err cleared, beat_cnt=0.
//   AGU_enable rises the cycle after acceptance.
//  RUN: AGU_enable=1 if stage_idx<K1_STAGES; else AGU_enable_k2=1 and LAST_STAGE=1.
//   beat_cnt++ on each BN_MA_out_en.
//   On AGU_done_out: drop enables next cycle; compare the final beat count (including a
//   beat in the same cycle) against BEATS_K1 or BEATS_K2; mismatch sets beat_err; go DRAIN.
//   Never more than one enable high at a time.
//  DRAIN: drain_cnt counts DRAIN_CYCLES; LAST_STAGE holds its RUN value.
//   On expiry: if stage_idx==K1_STAGES go DONE, else stage_idx++, beat_cnt=0, go RUN.
//  DONE: done=1 for one cycle, LAST_STAGE=0, go IDLE. start_ready returns 1 the next cycle.
//  start_valid outside IDLE is ignored; no queuing.
//  AGU_done_out outside RUN is ignored. BN_MA_out_en outside RUN is ignored, not counted.
//  beat_cnt saturates at all-ones; width is $clog2(max(BEATS_K1,BEATS_K2)+1)+1.
//  Latency: accept -> first enable = 1 cycle; AGU_done_out -> next enable = DRAIN_CYCLES+1.
// CONFIGURATION
//  STAGE_CTRL_TIMEOUT_EN defined: a per-stage cycle counter runs in RUN.
//   When it reaches TIMEOUT, timeout_err is set, the enable drops, and the FSM goes to DONE
//   (done still pulses).
//  Undefined: no counter is built; timeout_err is tied 0; RUN waits for AGU_done_out forever.
// STRUCTURE
//  ntt_ctrl_pkg: stage_state_e {IDLE,RUN,DRAIN,DONE}; the stage-count and beat-count
//   constants; stage_idx width typedef.
//  Sub-module ntt_stage_cnt: a loadable down-counter, reused for drain and timeout.
//   Everything else is in this module.
// TESTING
//  1 K1_STAGES=3, exact beats, DRAIN_CYCLES=8: AGU_enable in stages 0,1,2, then
//    AGU_enable_k2+LAST_STAGE in stage 3. done pulses once; beat_err=0.
//  2 Stage 1 returns 255 beats: beat_err=1 and stays set; sequence still completes.
//    The next start clears beat_err.
//  3 start_valid held high through a whole run: exactly one transform; a second is accepted
//    only after start_ready=1.
//  4 rst=0 for 1 cycle during stage 2 RUN: next cycle all enables=0, busy=0, start_ready=1;
//    no done.
//  5 AGU_done_out coincident with the last BN_MA_out_en: that beat is counted (256 -> no error).
//  6 STAGE_CTRL_TIMEOUT_EN, TIMEOUT=100, AGU_done_out never sent: enable drops after 100 cycles;
//    timeout_err=1; done pulses.

Source files
------------

// File: rtl/ntt_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ntt_ctrl_pkg
//   Shared types and constants for the NTT stage controller.
//   - stage_state_e : controller FSM states
//   - *_DEF         : default stage-count / beat-count / timing constants
//   - stage_idx_t   : stage_idx width for the default stage count
//   - max2, cnt_width : elaboration-time sizing helpers
// ----------------------------------------------------------------------------
package ntt_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } stage_state_e;

    localparam int K1_STAGES_DEF    = 3;
    localparam int BEATS_K1_DEF     = 256;
    localparam int BEATS_K2_DEF     = 2048;
    localparam int DRAIN_CYCLES_DEF = 8;
    localparam int TIMEOUT_DEF      = 4096;

    // Holds 0..K1_STAGES_DEF; the top derives its own width when K1_STAGES is overridden.
    typedef logic [$clog2(K1_STAGES_DEF + 1) - 1:0] stage_idx_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold a down-counter preload of n-1 (never narrower than 1).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ntt_stage_cnt.sv
// ----------------------------------------------------------------------------
// ntt_stage_cnt
//   Loadable down-counter that stops at zero. Used for the inter-stage drain
//   gap and for the per-stage timeout.
//   clk       in   clock
//   rst       in   synchronous reset, active-low
//   load      in   preload load_val (wins over dec)
//   load_val  in   W-bit preload value
//   dec       in   decrement by one while non-zero
//   zero      out  count is zero
// ----------------------------------------------------------------------------
module ntt_stage_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples its inputs from before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ntt_stage_ctrl.sv
// ----------------------------------------------------------------------------
// ntt_stage_ctrl
//   Upstream sequencer for the AGU integration block. Walks one transform
//   through K1_STAGES radix-16 stages and a final radix-2 stage, inserting a
//   DRAIN_CYCLES gap after each stage and checking per-stage beat counts.
//
//   Optional feature: define STAGE_CTRL_TIMEOUT_EN to build a per-stage
//   watchdog (TIMEOUT cycles in RUN -> timeout_err, enable drops, go DONE).
//   Without it timeout_err is tied 0 and RUN waits for AGU_done_out forever.
//
//   clk            in   clock
//   rst            in   synchronous reset, active-low
//   start_valid    in   request a full transform
//   start_ready    out  high in IDLE
//   AGU_done_out   in   end-of-stage pulse
//   BN_MA_out_en   in   one address beat
//   AGU_enable     out  radix-16 stage run level
//   AGU_enable_k2  out  radix-2 stage run level
//   LAST_STAGE     out  radix-2 path select (final RUN and its DRAIN)
//   stage_idx      out  current stage 0..K1_STAGES
//   busy           out  not IDLE
//   done           out  one-cycle completion pulse
//   beat_err       out  sticky beat-count mismatch, cleared on start
//   timeout_err    out  sticky stage timeout
// ----------------------------------------------------------------------------
module ntt_stage_ctrl
    import ntt_ctrl_pkg::*;
#(
    parameter int K1_STAGES    = K1_STAGES_DEF,
    parameter int BEATS_K1     = BEATS_K1_DEF,
    parameter int BEATS_K2     = BEATS_K2_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_valid,
    output logic                               start_ready,
    input  logic                               AGU_done_out,
    input  logic                               BN_MA_out_en,
    output logic                               AGU_enable,
    output logic                               AGU_enable_k2,
    output logic                               LAST_STAGE,
    output logic [$clog2(K1_STAGES + 1) - 1:0] stage_idx,
    output logic                               busy,
    output logic                               done,
    output logic                               beat_err,
    output logic                               timeout_err
);

    localparam int SW = $clog2(K1_STAGES + 1);
    localparam int BW = $clog2(max2(BEATS_K1, BEATS_K2) + 1) + 1;
    // Both counter instances share one width so the drain and timeout
    // preloads always fit.
    localparam int CW = cnt_width(max2(DRAIN_CYCLES, TIMEOUT));

    localparam logic [SW-1:0] LAST_IDX   = SW'(K1_STAGES);
    localparam logic [BW-1:0] EXP_K1     = BW'(BEATS_K1);
    localparam logic [BW-1:0] EXP_K2     = BW'(BEATS_K2);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

    stage_state_e  state, state_nxt;
    logic [BW-1:0] beat_cnt;
    logic [BW-1:0] beat_total;
    logic [BW-1:0] exp_beats;
    logic          is_last;
    logic          drain_load;
    logic          drain_zero;
    logic          timeout_hit;
    logic          beat_err_q;

    assign is_last   = (stage_idx == LAST_IDX);
    assign exp_beats = is_last ? EXP_K2 : EXP_K1;

    // Final count includes a beat arriving in the same cycle as AGU_done_out;
    // the counter sticks at all-ones rather than wrapping.
    assign beat_total = (BN_MA_out_en && (beat_cnt != '1)) ? beat_cnt + 1'b1 : beat_cnt;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        drain_load = 1'b0;
        case (state)
            IDLE: begin
                if (start_valid) state_nxt = RUN;
            end
            RUN: begin
                if (AGU_done_out) begin
                    state_nxt  = DRAIN;
                    drain_load = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DRAIN: begin
                if (drain_zero) state_nxt = is_last ? DONE : RUN;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            stage_idx  <= '0;
            beat_cnt   <= '0;
            beat_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        stage_idx  <= '0;
                        beat_cnt   <= '0;
                        beat_err_q <= 1'b0;
                    end
                end
                RUN: begin
                    beat_cnt <= beat_total;
                    if (AGU_done_out && (beat_total != exp_beats)) beat_err_q <= 1'b1;
                end
                DRAIN: begin
                    if (drain_zero && !is_last) begin
                        stage_idx <= stage_idx + 1'b1;
                        beat_cnt  <= '0;
                    end
                end
                DONE: begin
                    stage_idx <= '0;
                end
                default: ;
            endcase
        end
    end

    // Preloaded to DRAIN_CYCLES-1 on AGU_done_out, so DRAIN lasts exactly
    // DRAIN_CYCLES cycles and the next enable rises DRAIN_CYCLES+1 after done.
    ntt_stage_cnt #(.W(CW)) u_drain_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (drain_load),
        .load_val (DRAIN_LOAD),
        .dec      (state == DRAIN),
        .zero     (drain_zero)
    );

`ifdef STAGE_CTRL_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT - 1);

    logic run_entry;
    logic to_zero;
    logic timeout_err_q;

    assign run_entry = ((state == IDLE) && start_valid) ||
                       ((state == DRAIN) && drain_zero && !is_last);

    ntt_stage_cnt #(.W(CW)) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (run_entry),
        .load_val (TIMEOUT_LOAD),
        .dec      (state == RUN),
        .zero     (to_zero)
    );

    // Counter reaches zero in the TIMEOUT-th RUN cycle; a real AGU_done_out
    // in that same cycle takes precedence.
    assign timeout_hit = (state == RUN) && to_zero && !AGU_done_out;

    always_ff @(posedge clk) begin
        if (!rst) begin
            timeout_err_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs decoded from state; only one enable can ever be high.
    // ------------------------------------------------------------------
    assign start_ready   = (state == IDLE);
    assign busy          = (state != IDLE);
    assign AGU_enable    = (state == RUN) && !is_last;
    assign AGU_enable_k2 = (state == RUN) && is_last;
    assign LAST_STAGE    = ((state == RUN) || (state == DRAIN)) && is_last;
    assign done          = (state == DONE);
    assign beat_err      = beat_err_q;

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ntt_stage_ctrl
//   Table of whole-transform vectors driven through an AGU model, with a
//   scoreboard of expected per-stage enables and end-of-transform results,
//   plus hand-written reset, idle-noise and (optional) timeout sequences.
// ----------------------------------------------------------------------------
module tb_ntt_stage_ctrl;
    import ntt_ctrl_pkg::*;

    localparam int K1S = 3;
    localparam int DRN = 8;
`ifdef STAGE_CTRL_TIMEOUT_EN
    localparam int K1B   = 32;
    localparam int K2B   = 80;
    localparam int TB_TO = 100;
`else
    localparam int K1B   = 256;
    localparam int K2B   = 2048;
    localparam int TB_TO = 4096;
`endif

    typedef struct {
        int beats [4];
        bit coin;
        bit hold;
        bit exp_err;
    } vec_t;

    typedef struct {
        int idx;
        bit en;
        bit en2;
        bit last;
    } exp_stage_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_valid;
    logic       start_ready;
    logic       AGU_done_out;
    logic       BN_MA_out_en;
    logic       AGU_enable;
    logic       AGU_enable_k2;
    logic       LAST_STAGE;
    stage_idx_t stage_idx;
    logic       busy;
    logic       done;
    logic       beat_err;
    logic       timeout_err;

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    int n_onehot = 0;

    exp_stage_t sb_q[$];
    bit         exp_done_q[$];
    vec_t       vecs [6];

    ntt_stage_ctrl #(
        .K1_STAGES    (K1S),
        .BEATS_K1     (K1B),
        .BEATS_K2     (K2B),
        .DRAIN_CYCLES (DRN),
        .TIMEOUT      (TB_TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .AGU_done_out  (AGU_done_out),
        .BN_MA_out_en  (BN_MA_out_en),
        .AGU_enable    (AGU_enable),
        .AGU_enable_k2 (AGU_enable_k2),
        .LAST_STAGE    (LAST_STAGE),
        .stage_idx     (stage_idx),
        .busy          (busy),
        .done          (done),
        .beat_err      (beat_err),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) n_done++;
        if (AGU_enable && AGU_enable_k2) n_onehot++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Entered at the first RUN cycle of stage s; leaves at the cycle the next
    // enable (or done) is visible.
    task automatic run_stage(input int s, input int n, input bit coin);
        exp_stage_t e;
        int lat;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(1), 32'(0));
            return;
        end
        e = sb_q.pop_front();
        check("stage_idx", 32'(stage_idx), 32'(e.idx));
        check("agu_enable", 32'(AGU_enable), 32'(e.en));
        check("agu_enable_k2", 32'(AGU_enable_k2), 32'(e.en2));
        check("last_stage_run", 32'(LAST_STAGE), 32'(e.last));
        check("start_ready_busy", 32'(start_ready), 32'(0));
        if (s == 0) check("beat_err_cleared", 32'(beat_err), 32'(0));
        for (int b = 0; b < n; b++) begin
            BN_MA_out_en = 1'b1;
            AGU_done_out = coin && (b == n - 1);
            @(negedge clk);
        end
        BN_MA_out_en = 1'b0;
        if (!coin || n == 0) begin
            AGU_done_out = 1'b1;
            @(negedge clk);
        end
        AGU_done_out = 1'b0;
        check("enable_drop", 32'(AGU_enable | AGU_enable_k2), 32'(0));
        check("last_stage_drain", 32'(LAST_STAGE), 32'(s == K1S));
        lat = 1;
        while (!(AGU_enable || AGU_enable_k2 || done) && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("drain_latency", 32'(lat), 32'(DRN + 1));
    endtask

    task automatic run_transform(input vec_t v);
        int  done_before;
        bit  exp_e;
        done_before = n_done;
        for (int s = 0; s <= K1S; s++)
            sb_q.push_back('{idx: s, en: (s < K1S), en2: (s == K1S), last: (s == K1S)});
        exp_done_q.push_back(v.exp_err);
        check("ready_before_start", 32'(start_ready), 32'(1));
        start_valid = 1'b1;
        @(negedge clk);
        if (!v.hold) start_valid = 1'b0;
        check("accept_to_enable", 32'(AGU_enable), 32'(1));
        for (int s = 0; s <= K1S; s++) run_stage(s, v.beats[s], v.coin);
        exp_e = exp_done_q.pop_front();
        check("done_pulse", 32'(done), 32'(1));
        check("last_stage_done", 32'(LAST_STAGE), 32'(0));
        check("beat_err", 32'(beat_err), 32'(exp_e));
        @(negedge clk);
        check("ready_after_done", 32'(start_ready), 32'(1));
        check("idle_not_busy", 32'(busy), 32'(0));
        check("done_single", 32'(n_done - done_before), 32'(1));
        start_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b0;
        start_valid  = 1'b0;
        AGU_done_out = 1'b0;
        BN_MA_out_en = 1'b0;

        vecs[0] = '{beats: '{K1B, K1B, K1B, K2B},     coin: 1'b0, hold: 1'b0, exp_err: 1'b0};
        vecs[1] = '{beats: '{K1B, K1B - 1, K1B, K2B}, coin: 1'b0, hold: 1'b0, exp_err: 1'b1};
        vecs[2] = '{beats: '{K1B, K1B, K1B, K2B},     coin: 1'b0, hold: 1'b1, exp_err: 1'b0};
        vecs[3] = '{beats: '{K1B, K1B, K1B, K2B},     coin: 1'b1, hold: 1'b0, exp_err: 1'b0};
        vecs[4] = '{beats: '{K1B, K1B, K1B, K2B + 1}, coin: 1'b1, hold: 1'b0, exp_err: 1'b1};
        vecs[5] = '{beats: '{K1B + 1, K1B, K1B, K2B}, coin: 1'b0, hold: 1'b0, exp_err: 1'b1};

        repeat (3) @(negedge clk);
        check("rst_start_ready", 32'(start_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_enables", 32'({AGU_enable, AGU_enable_k2, LAST_STAGE}), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_errs", 32'({beat_err, timeout_err}), 32'(0));
        check("rst_stage_idx", 32'(stage_idx), 32'(0));
        rst = 1'b1;
        @(negedge clk);

        // Strobes outside RUN must not start anything.
        BN_MA_out_en = 1'b1;
        AGU_done_out = 1'b1;
        @(negedge clk);
        BN_MA_out_en = 1'b0;
        AGU_done_out = 1'b0;
        @(negedge clk);
        check("idle_noise_busy", 32'(busy), 32'(0));

        foreach (vecs[i]) run_transform(vecs[i]);

        // Reset pulse in the middle of stage 2.
        begin
            int done_before;
            done_before = n_done;
            sb_q.delete();
            for (int s = 0; s <= K1S; s++)
                sb_q.push_back('{idx: s, en: (s < K1S), en2: (s == K1S), last: (s == K1S)});
            start_valid = 1'b1;
            @(negedge clk);
            start_valid = 1'b0;
            run_stage(0, K1B, 1'b0);
            run_stage(1, K1B, 1'b0);
            check("rst_test_stage2", 32'(stage_idx), 32'(2));
            BN_MA_out_en = 1'b1;
            repeat (10) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            BN_MA_out_en = 1'b0;
            check("midrst_enables", 32'({AGU_enable, AGU_enable_k2, LAST_STAGE}), 32'(0));
            check("midrst_busy", 32'(busy), 32'(0));
            check("midrst_ready", 32'(start_ready), 32'(1));
            repeat (20) @(negedge clk);
            check("midrst_no_done", 32'(n_done - done_before), 32'(0));
            sb_q.delete();
        end

`ifdef STAGE_CTRL_TIMEOUT_EN
        begin
            int cnt;
            int done_before;
            done_before = n_done;
            start_valid = 1'b1;
            @(negedge clk);
            start_valid = 1'b0;
            cnt = 0;
            while (AGU_enable && cnt < 4 * TB_TO) begin
                cnt++;
                @(negedge clk);
            end
            check("timeout_cycles", 32'(cnt), 32'(TB_TO));
            check("timeout_done", 32'(done), 32'(1));
            check("timeout_err", 32'(timeout_err), 32'(1));
            @(negedge clk);
            check("timeout_done_count", 32'(n_done - done_before), 32'(1));
            check("timeout_idle", 32'(busy), 32'(0));
        end
`else
        check("timeout_err_tied", 32'(timeout_err), 32'(0));
`endif

        check("one_hot_enables", 32'(n_onehot), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
